// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, tracks the Gray phase and
// keeps a saturating position count. Define QUAD_X4_EN for x4 resolution (x1 otherwise).
module quad_decoder #(
   parameter int COUNTER_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     quad_a,
   input  logic                     quad_b,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     step,
   output logic                     up_down_n,
   output logic                     ovflw,
   output logic                     err
);

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      TRACK = 4'b0010,
      OVFLW = 4'b0100,
      ERR   = 4'b1000
   } state_t;

   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};
   localparam logic [COUNTER_WIDTH-1:0] CNT_MIN = {COUNTER_WIDTH{1'b0}};

   // Position of a {A,B} pair along the up sequence 00->10->11->01.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      case (ab)
         2'b00:   gray_idx = 2'd0;
         2'b10:   gray_idx = 2'd1;
         2'b11:   gray_idx = 2'd2;
         default: gray_idx = 2'd3;
      endcase
   endfunction

   // A step that would leave the counter range saturates instead of wrapping.
   function automatic logic limit_hit(input logic [COUNTER_WIDTH-1:0] cnt, input logic up);
      limit_hit = up ? (cnt == CNT_MAX) : (cnt == CNT_MIN);
   endfunction

   logic       a_meta_p0, b_meta_p0;
   logic       a_sync_p1, b_sync_p1;
   logic [1:0] prev_ab_p2;
   logic [1:0] cur_ab;
   logic       moved, illegal, dir_up, counted;

   state_t                   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] count_d;
   logic                     step_d, dir_d;

   // Stage p0/p1: two-flop synchronizers; p2: previous synchronized pair
   always_ff @(posedge clk) begin
      if (rst) begin
         a_meta_p0  <= 1'b0;
         b_meta_p0  <= 1'b0;
         a_sync_p1  <= 1'b0;
         b_sync_p1  <= 1'b0;
         prev_ab_p2 <= 2'b00;
      end else begin
         a_meta_p0  <= quad_a;
         b_meta_p0  <= quad_b;
         a_sync_p1  <= a_meta_p0;
         b_sync_p1  <= b_meta_p0;
         prev_ab_p2 <= cur_ab;
      end
   end

   assign cur_ab  = {a_sync_p1, b_sync_p1};
   assign moved   = (cur_ab != prev_ab_p2);
   assign illegal = (cur_ab == ~prev_ab_p2);
   assign dir_up  = (gray_idx(cur_ab) == gray_idx(prev_ab_p2) + 2'd1);

`ifdef QUAD_X4_EN
   assign counted = moved && !illegal;
`else
   // Only the phase edge between 01 and 00 counts; the rest is tracked silently.
   assign counted = ((prev_ab_p2 == 2'b01) && (cur_ab == 2'b00)) ||
                    ((prev_ab_p2 == 2'b00) && (cur_ab == 2'b01));
`endif

   always_comb begin
      state_d = state_q;
      count_d = count;
      step_d  = 1'b0;
      dir_d   = up_down_n;
      case (state_q)
         IDLE: begin
            if (en) state_d = TRACK;
         end
         TRACK: begin
            if (!en) begin
               state_d = IDLE;
            end else if (illegal) begin
               state_d = ERR;
            end else if (counted) begin
               if (limit_hit(count, dir_up)) begin
                  state_d = OVFLW;
               end else begin
                  count_d = dir_up ? (count + CNT_ONE) : (count - CNT_ONE);
                  step_d  = 1'b1;
                  dir_d   = dir_up;
               end
            end
         end
         OVFLW:   state_d = OVFLW;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   // Stage p2 -> outputs: state and registered count/step/direction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count     <= CNT_MIN;
         step      <= 1'b0;
         up_down_n <= 1'b1;
      end else begin
         state_q   <= state_d;
         count     <= count_d;
         step      <= step_d;
         up_down_n <= dir_d;
      end
   end

   assign ovflw = (state_q == OVFLW);
   assign err   = (state_q == ERR);

endmodule
